control_botones: RTL and testbench

- Input conditioner and command sequencer sitting between the board push-buttons and the central pet FSM.
- Synchronises and debounces five raw buttons, then arbitrates simultaneous presses into single-cycle action pulses.
- Runs the test-mode protocol: a long press of the test button enters or leaves test mode, and short presses select the forced state code (1-9) handed to the FSM.

---
 rtl/control_botones.sv | 234 +++++++++++++++++++++++
 tb/tb_control_botones.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_botones.sv
// -----------------------------------------------------------------------------
// control_botones
// Input conditioner and command sequencer between the board push-buttons and
// the pet FSM. Each raw button is synchronised and debounced. Rising edges of
// the four action buttons are arbitrated into single-cycle pulses. The test
// button runs a long-press / short-press protocol that enters or leaves test
// mode and selects a forced state code.
//
// Ports
//   clk            in   system clock
//   rst            in   asynchronous reset, active-high
//   btn_sleep_raw  in   raw sleep button (async, active-high)
//   btn_awake_raw  in   raw awake button (async, active-high)
//   btn_feed_raw   in   raw feed button  (async, active-high)
//   btn_play_raw   in   raw play button  (async, active-high)
//   btn_test_raw   in   raw test button  (async, active-high)
//   sleep_pulse    out  one-cycle sleep command
//   awake_pulse    out  one-cycle awake command
//   feed_pulse     out  one-cycle feed command
//   play_pulse     out  one-cycle play command
//   test_mode      out  high while test mode is active
//   test_sel       out  forced state code, 0 = none, 1..9 valid
//
// Test FSM
//   state     | meaning
//   NORMAL    | normal operation, action pulses enabled
//   N_HOLD    | test held from NORMAL, timing a possible long press
//   T_WAITREL | test mode just entered, waiting for the entry press to end
//   TEST      | test mode idle, waiting for a test press
//   T_HOLD    | test held in test mode, short press selects, long press exits
//   EXIT      | test mode left, test_sel still presented for EXIT_HOLD cycles
//   E_WAITREL | waiting for the exit press to end before returning to NORMAL
// -----------------------------------------------------------------------------
module control_botones #(
    parameter int DEBOUNCE_MAX = 500000,
    parameter int LONG_PRESS   = 150000000,
    parameter int EXIT_HOLD    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_sleep_raw,
    input  logic       btn_awake_raw,
    input  logic       btn_feed_raw,
    input  logic       btn_play_raw,
    input  logic       btn_test_raw,
    output logic       sleep_pulse,
    output logic       awake_pulse,
    output logic       feed_pulse,
    output logic       play_pulse,
    output logic       test_mode,
    output logic [3:0] test_sel
);

    localparam int DB_W   = $clog2(DEBOUNCE_MAX);
    localparam int HOLD_W = $clog2(LONG_PRESS);
    localparam int EXIT_W = (EXIT_HOLD > 1) ? $clog2(EXIT_HOLD) : 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_MAX - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS - 1);
    localparam logic [EXIT_W-1:0] EXIT_LAST = EXIT_W'(EXIT_HOLD - 1);

    // Button bit positions inside the conditioned vectors
    localparam int B_SLEEP = 0;
    localparam int B_AWAKE = 1;
    localparam int B_FEED  = 2;
    localparam int B_PLAY  = 3;
    localparam int B_TEST  = 4;

    typedef enum logic [2:0] {
        NORMAL    = 3'd0,
        N_HOLD    = 3'd1,
        T_WAITREL = 3'd2,
        TEST      = 3'd3,
        T_HOLD    = 3'd4,
        EXIT      = 3'd5,
        E_WAITREL = 3'd6
    } state_t;

    logic [4:0]      raw;
    logic [4:0]      sync1_q;
    logic [4:0]      sync2_q;
    logic [4:0]      db_q;
    logic [4:0]      db_prev_q;
    logic [DB_W-1:0] db_cnt_q [5];
    logic [4:0]      rise;

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [EXIT_W-1:0]   exit_cnt_q, exit_cnt_d;
    logic                test_mode_q, test_mode_d;
    logic [3:0]          test_sel_q, test_sel_d;
    logic [3:0]          pulse_q, pulse_d;

    assign raw = {btn_test_raw, btn_play_raw, btn_feed_raw, btn_awake_raw, btn_sleep_raw};

    // Synchroniser and per-button stability counter. The counter only runs
    // while the synchronised input disagrees with the debounced level; any
    // agreement (a bounce back) restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            for (int i = 0; i < 5; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= raw;
            sync2_q   <= sync1_q;
            db_prev_q <= db_q;
            for (int i = 0; i < 5; i++) begin
                if (sync2_q[i] == db_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_LAST) begin
                    db_q[i]     <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    assign rise = db_q & ~db_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= NORMAL;
            hold_cnt_q  <= '0;
            exit_cnt_q  <= '0;
            test_mode_q <= 1'b0;
            test_sel_q  <= 4'd0;
            pulse_q     <= 4'd0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            exit_cnt_q  <= exit_cnt_d;
            test_mode_q <= test_mode_d;
            test_sel_q  <= test_sel_d;
            pulse_q     <= pulse_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        exit_cnt_d  = exit_cnt_q;
        test_mode_d = test_mode_q;
        test_sel_d  = test_sel_q;
        pulse_d     = 4'd0;

        case (state_q)
            NORMAL: begin
                if (rise[B_TEST]) begin
                    hold_cnt_d = '0;
                    state_d    = N_HOLD;
                end
            end
            N_HOLD: begin
                if (!db_q[B_TEST]) begin
                    state_d = NORMAL;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    test_mode_d = 1'b1;
                    test_sel_d  = 4'd0;
                    state_d     = T_WAITREL;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            T_WAITREL: begin
                // Swallow the rest of the entry press so it is not a selection
                if (!db_q[B_TEST]) begin
                    state_d = TEST;
                end
            end
            TEST: begin
                if (rise[B_TEST]) begin
                    hold_cnt_d = '0;
                    state_d    = T_HOLD;
                end
            end
            T_HOLD: begin
                if (!db_q[B_TEST]) begin
                    test_sel_d = (test_sel_q == 4'd9) ? 4'd1 : test_sel_q + 4'd1;
                    state_d    = TEST;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    test_mode_d = 1'b0;
                    exit_cnt_d  = '0;
                    state_d     = EXIT;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            EXIT: begin
                if (exit_cnt_q == EXIT_LAST) begin
                    test_sel_d = 4'd0;
                    state_d    = E_WAITREL;
                end else begin
                    exit_cnt_d = exit_cnt_q + EXIT_W'(1);
                end
            end
            E_WAITREL: begin
                if (!db_q[B_TEST]) begin
                    state_d = NORMAL;
                end
            end
            default: begin
                state_d = NORMAL;
            end
        endcase

        // Fixed priority awake > sleep > feed > play; losers are dropped.
        if (state_q == NORMAL) begin
            if (rise[B_AWAKE]) begin
                pulse_d[B_AWAKE] = 1'b1;
            end else if (rise[B_SLEEP]) begin
                pulse_d[B_SLEEP] = 1'b1;
            end else if (rise[B_FEED]) begin
                pulse_d[B_FEED] = 1'b1;
            end else if (rise[B_PLAY]) begin
                pulse_d[B_PLAY] = 1'b1;
            end
        end
    end

    assign sleep_pulse = pulse_q[B_SLEEP];
    assign awake_pulse = pulse_q[B_AWAKE];
    assign feed_pulse  = pulse_q[B_FEED];
    assign play_pulse  = pulse_q[B_PLAY];
    assign test_mode   = test_mode_q;
    assign test_sel    = test_sel_q;

endmodule

// File: tb/tb_control_botones.sv
// -----------------------------------------------------------------------------
// tb_control_botones
// Directed scenarios followed by randomized button activity. A behavioural
// model (sample history window for debounce, press timestamps for the test
// protocol) predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_control_botones;

    localparam int DM = 4;
    localparam int LP = 20;
    localparam int EH = 4;

    localparam logic [4:0] M_SLEEP = 5'b00001;
    localparam logic [4:0] M_AWAKE = 5'b00010;
    localparam logic [4:0] M_FEED  = 5'b00100;
    localparam logic [4:0] M_PLAY  = 5'b01000;
    localparam logic [4:0] M_TEST  = 5'b10000;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] raw_v;
    logic       sleep_pulse, awake_pulse, feed_pulse, play_pulse, test_mode;
    logic [3:0] test_sel;

    int n_cmp = 0;
    int n_bad = 0;

    int cnt_s, cnt_a, cnt_f, cnt_p, cnt_h7;

    // Model state
    bit [DM+1:0] hist [5];
    bit [4:0]    lv1, lv2;
    bit [3:0]    mp;
    bit          m_mode, m_press, m_wait, m_exiting;
    int          m_sel, m_start, m_exit_at, m_n;

    control_botones #(
        .DEBOUNCE_MAX(DM),
        .LONG_PRESS  (LP),
        .EXIT_HOLD   (EH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_sleep_raw(raw_v[0]),
        .btn_awake_raw(raw_v[1]),
        .btn_feed_raw (raw_v[2]),
        .btn_play_raw (raw_v[3]),
        .btn_test_raw (raw_v[4]),
        .sleep_pulse  (sleep_pulse),
        .awake_pulse  (awake_pulse),
        .feed_pulse   (feed_pulse),
        .play_pulse   (play_pulse),
        .test_mode    (test_mode),
        .test_sel     (test_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] dut_vec();
        return {sleep_pulse, awake_pulse, feed_pulse, play_pulse, test_mode, test_sel};
    endfunction

    function automatic logic [8:0] model_vec();
        return {mp, m_mode, 4'(m_sel)};
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 5; b++) hist[b] = '0;
        lv1 = '0; lv2 = '0; mp = '0;
        m_mode = 0; m_press = 0; m_wait = 0; m_exiting = 0;
        m_sel = 0; m_start = 0; m_exit_at = 0;
    endtask

    // One clock edge of the model; n = index of this edge.
    task automatic model_step();
        bit [4:0] rise;
        bit [4:0] nl;
        bit       quiet;
        bit       flip;
        int       n;
        m_n++;
        n     = m_n;
        rise  = lv1 & ~lv2;
        quiet = !m_mode && !m_press && !m_wait && !m_exiting;

        mp = 4'b0000;  // {sleep, awake, feed, play}
        if (quiet) begin
            if (rise[1])      mp = 4'b0100;
            else if (rise[0]) mp = 4'b1000;
            else if (rise[2]) mp = 4'b0010;
            else if (rise[3]) mp = 4'b0001;
        end

        if (m_wait) begin
            if (!lv1[4]) m_wait = 0;
        end else if (m_exiting) begin
            if (n == m_exit_at) begin
                m_sel = 0; m_exiting = 0; m_wait = 1;
            end
        end else if (m_press) begin
            if (!lv1[4]) begin
                m_press = 0;
                if (m_mode) m_sel = (m_sel == 9) ? 1 : m_sel + 1;
            end else if (n == m_start + LP + 1) begin
                m_press = 0;
                if (!m_mode) begin
                    m_mode = 1; m_sel = 0; m_wait = 1;
                end else begin
                    m_mode = 0; m_exiting = 1; m_exit_at = n + EH;
                end
            end
        end else if (rise[4]) begin
            m_press = 1;
            m_start = n - 1;
        end

        // Level flips once the last DM synchronised samples all disagree
        for (int b = 0; b < 5; b++) begin
            flip = 1;
            for (int i = 1; i <= DM; i++) if (hist[b][i] == lv1[b]) flip = 0;
            nl[b]   = flip ? ~lv1[b] : lv1[b];
            hist[b] = {hist[b][DM:0], raw_v[b]};
        end
        lv2 = lv1;
        lv1 = nl;
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            model_step();
            #1;
            chk("cycle", dut_vec(), model_vec());
        end
    end

    always @(posedge clk) begin
        #1;
        if (sleep_pulse) cnt_s++;
        if (awake_pulse) cnt_a++;
        if (feed_pulse)  cnt_f++;
        if (play_pulse)  cnt_p++;
        if (!test_mode && test_sel == 4'd7) cnt_h7++;
    end

    task automatic clr_cnt();
        cnt_s = 0; cnt_a = 0; cnt_f = 0; cnt_p = 0; cnt_h7 = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hold(input logic [4:0] m, input int n);
        @(negedge clk);
        raw_v = raw_v | m;
        idle(n);
        raw_v = raw_v & ~m;
    endtask

    task automatic short_test();
        hold(M_TEST, 8);
        idle(12);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("reset_outputs", dut_vec(), 9'd0);
        @(negedge clk);
        raw_v = '0;
        rst   = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_sel;
        int op;
        int b;
        rst   = 1'b1;
        raw_v = '0;
        m_n   = 0;
        model_reset();
        clr_cnt();
        #2;
        chk("reset_state", dut_vec(), 9'd0);
        idle(2);
        chk("reset_held", dut_vec(), 9'd0);
        rst = 1'b0;
        idle(5);

        // Bounce on feed, then a steady hold
        clr_cnt();
        for (int i = 0; i < 6; i++) begin
            raw_v[2] = ~raw_v[2];
            idle(2);
        end
        raw_v[2] = 1'b1;
        idle(40);
        raw_v[2] = 1'b0;
        idle(15);
        chk("bounce_feed_cnt", cnt_f, 1);

        // Arbitration
        clr_cnt();
        hold(M_SLEEP | M_PLAY, 20);
        idle(15);
        chk("arb_sleep_cnt", cnt_s, 1);
        chk("arb_play_cnt", cnt_p, 0);
        clr_cnt();
        hold(M_AWAKE | M_SLEEP, 20);
        idle(15);
        chk("arb_awake_cnt", cnt_a, 1);
        chk("arb_sleep_drop", cnt_s, 0);

        // Short test press in NORMAL
        clr_cnt();
        hold(M_TEST, 10);
        idle(15);
        chk("short_mode", test_mode, 0);
        chk("short_pulses", cnt_s + cnt_a + cnt_f + cnt_p, 0);

        // Enter test mode and select
        hold(M_TEST, 30);
        idle(12);
        chk("enter_mode", test_mode, 1);
        chk("enter_sel", test_sel, 0);
        repeat (3) short_test();
        chk("sel_three", test_sel, 3);
        exp_sel = 3;
        clr_cnt();
        for (int i = 0; i < 10; i++) begin
            exp_sel = (exp_sel == 9) ? 1 : exp_sel + 1;
            if (i == 4) begin
                hold(M_PLAY, 10);
                idle(10);
            end
            short_test();
            chk("sel_seq", test_sel, exp_sel);
        end
        chk("test_play_cnt", cnt_p, 0);
        repeat (3) short_test();
        chk("sel_seven", test_sel, 7);

        // Exit
        clr_cnt();
        hold(M_TEST, 30);
        idle(12);
        chk("exit_mode", test_mode, 0);
        chk("exit_sel", test_sel, 0);
        chk("exit_hold_cycles", cnt_h7, EH);
        clr_cnt();
        hold(M_FEED, 10);
        idle(12);
        chk("after_exit_feed", cnt_f, 1);

        // Reset in the middle of T_HOLD
        hold(M_TEST, 30);
        idle(12);
        repeat (5) short_test();
        chk("pre_rst_sel", test_sel, 5);
        @(negedge clk);
        raw_v[4] = 1'b1;
        idle(10);
        do_reset();
        idle(5);
        clr_cnt();
        hold(M_SLEEP, 10);
        idle(12);
        chk("post_rst_sleep", cnt_s, 1);

        // Randomized activity, checked every cycle by the model
        for (int it = 0; it < 150; it++) begin
            op = $urandom_range(0, 9);
            if (op <= 3) begin
                b = $urandom_range(0, 3);
                repeat ($urandom_range(0, 8)) begin
                    @(negedge clk);
                    raw_v[b] = 1'($urandom_range(0, 1));
                end
                hold(5'($urandom_range(1, 15)), $urandom_range(3, 30));
                raw_v[3:0] = '0;
                idle($urandom_range(0, 12));
            end else if (op <= 6) begin
                hold(M_TEST, $urandom_range(3, 40));
                idle($urandom_range(0, 15));
            end else if (op == 7) begin
                repeat ($urandom_range(1, 10)) begin
                    @(negedge clk);
                    raw_v = 5'($urandom);
                end
                @(negedge clk);
                raw_v = '0;
                idle($urandom_range(1, 10));
            end else if (op == 8) begin
                idle($urandom_range(1, 15));
            end else begin
                if ($urandom_range(0, 3) == 0) do_reset();
                else idle(3);
            end
        end
        raw_v = '0;
        idle(30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
